gcd_job_sequencer: RTL and testbench

- Upstream feeder for the HLS `gcd` core. It buffers operand pairs from a valid/ready stream in a small FIFO.
- It launches one `gcd` job at a time through the `ap_start`/`ap_done`/`ap_idle` handshake.
- It returns each result with its operands on a valid/ready output stream.
- It handles zero operands locally and flags hung jobs with a timeout.

---
 rtl/gcd_job_sequencer_if.sv | 36 +++
 rtl/gcd_job_sequencer.sv | 157 +++++++++++++++
 tb/tb_gcd_job_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_job_sequencer_if.sv
// Stream and core-handshake bundle for gcd_job_sequencer; slave is the sequencer
// side, master is the job source / result sink / gcd core side.
interface gcd_job_sequencer_if #(
  parameter int unsigned W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W-1:0] gcd_a;
  logic [W-1:0] gcd_b;
  logic         gcd_start;
  logic         gcd_idle;
  logic         gcd_done;
  logic [W-1:0] gcd_return;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_a;
  logic [W-1:0] out_b;
  logic [W-1:0] out_gcd;
  logic         out_err;
  logic         busy;
  logic [15:0]  job_count;

  modport slave (
    input  in_valid, in_a, in_b, gcd_idle, gcd_done, gcd_return, out_ready,
    output in_ready, gcd_a, gcd_b, gcd_start, out_valid, out_a, out_b,
           out_gcd, out_err, busy, job_count
  );

  modport master (
    output in_valid, in_a, in_b, gcd_idle, gcd_done, gcd_return, out_ready,
    input  in_ready, gcd_a, gcd_b, gcd_start, out_valid, out_a, out_b,
           out_gcd, out_err, busy, job_count
  );
endinterface

// File: rtl/gcd_job_sequencer.sv
// Operand FIFO feeding an HLS gcd core one job at a time; zero operands are
// resolved locally and hung jobs are aborted after TIMEOUT cycles in RUN.
module gcd_job_sequencer #(
  parameter int unsigned W       = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  gcd_job_sequencer_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, RUN, RESULT} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  mem_a_q [DEPTH];
  logic [W-1:0]  mem_b_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic [W-1:0]  gcd_a_q, gcd_a_d, gcd_b_q, gcd_b_d;
  logic [W-1:0]  out_a_q, out_a_d, out_b_q, out_b_d, out_gcd_q, out_gcd_d;
  logic          out_err_q, out_err_d, out_valid_q, out_valid_d;
  logic [15:0]   job_count_q, job_count_d;

  logic          full, empty, push, pop;
  logic [W-1:0]  head_a, head_b;

  assign full   = (count_q == (AW+1)'(DEPTH));
  assign empty  = (count_q == '0);
  // Full blocks the push even when a pop frees a slot in the same cycle.
  assign push   = bus.in_valid && !full;
  assign head_a = mem_a_q[rd_ptr_q];
  assign head_b = mem_b_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    gcd_a_d     = gcd_a_q;
    gcd_b_d     = gcd_b_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_gcd_d   = out_gcd_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    job_count_d = job_count_q;
    pop         = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          if (head_a == '0 || head_b == '0) begin
            pop         = 1'b1;
            out_a_d     = head_a;
            out_b_d     = head_b;
            out_gcd_d   = head_a | head_b;
            out_err_d   = 1'b0;
            out_valid_d = 1'b1;
            state_d     = RESULT;
          end else if (bus.gcd_idle) begin
            pop     = 1'b1;
            gcd_a_d = head_a;
            gcd_b_d = head_b;
            out_a_d = head_a;
            out_b_d = head_b;
            tmo_d   = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        tmo_d = tmo_q + CW'(1);
        if (bus.gcd_done) begin
          out_gcd_d   = bus.gcd_return;
          out_err_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = RESULT;
        end else if (tmo_q == CW'(TIMEOUT - 1)) begin
          out_gcd_d   = '0;
          out_err_d   = 1'b1;
          out_valid_d = 1'b1;
          state_d     = RESULT;
        end
      end
      RESULT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          job_count_d = job_count_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tmo_q       <= '0;
      gcd_a_q     <= '0;
      gcd_b_q     <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_gcd_q   <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      job_count_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tmo_q       <= tmo_d;
      gcd_a_q     <= gcd_a_d;
      gcd_b_q     <= gcd_b_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_gcd_q   <= out_gcd_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
      job_count_q <= job_count_d;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q] <= bus.in_a;
      mem_b_q[wr_ptr_q] <= bus.in_b;
    end
  end

  assign bus.in_ready  = !full;
  assign bus.gcd_a     = gcd_a_q;
  assign bus.gcd_b     = gcd_b_q;
  // Low in the done cycle so the core is not relaunched.
  assign bus.gcd_start = (state_q == RUN) && !bus.gcd_done;
  assign bus.out_valid = out_valid_q;
  assign bus.out_a     = out_a_q;
  assign bus.out_b     = out_b_q;
  assign bus.out_gcd   = out_gcd_q;
  assign bus.out_err   = out_err_q;
  assign bus.busy      = (state_q != IDLE) || !empty;
  assign bus.job_count = job_count_q;
endmodule

// File: tb/tb_gcd_job_sequencer.sv
// Bench for gcd_job_sequencer with a behavioural gcd core and a result scoreboard.
module tb_gcd_job_sequencer;
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  gcd_job_sequencer_if #(.W(32)) bus ();

  gcd_job_sequencer #(.W(32), .DEPTH(4), .TIMEOUT(16)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] g;
    logic        e;
  } res_t;

  res_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_jobs = 16'd0;
  bit          start_seen = 1'b0;
  int          start_cycles = 0;

  function automatic logic [31:0] gcd_ref(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Behavioural gcd core: latches operands on start, done `lat` cycles later.
  logic        m_idle, m_done;
  logic [31:0] m_ret;
  int unsigned m_cnt;
  int unsigned lat = 5;
  bit          hang = 1'b0;

  always @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      m_idle <= 1'b1;
      m_done <= 1'b0;
      m_cnt  <= 0;
      m_ret  <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_idle) begin
        if (bus.gcd_start) begin
          m_idle <= 1'b0;
          m_cnt  <= lat;
          m_ret  <= gcd_ref(bus.gcd_a, bus.gcd_b);
        end
      end else if (m_cnt > 1) begin
        m_cnt <= m_cnt - 1;
      end else if (!hang) begin
        m_done <= 1'b1;
        m_idle <= 1'b1;
      end
    end
  end

  assign bus.gcd_idle   = m_idle;
  assign bus.gcd_done   = m_done;
  assign bus.gcd_return = m_ret;

  // Scoreboard: compare every output handshake against the oldest expected job.
  always @(negedge ap_clk) begin
    if (!ap_rst) begin
      if (bus.gcd_start) begin
        start_seen = 1'b1;
        start_cycles++;
      end
      if (bus.out_valid && bus.out_ready) begin
        res_t e;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: got a=%0d b=%0d gcd=%0d err=%0d, required no result",
                   bus.out_a, bus.out_b, bus.out_gcd, bus.out_err);
        end else begin
          e = sb.pop_front();
          if ({bus.out_a, bus.out_b, bus.out_gcd, bus.out_err} !== {e.a, e.b, e.g, e.e}) begin
            fails++;
            $display("FAIL sb_result: got a=%0d b=%0d gcd=%0d err=%0d, required a=%0d b=%0d gcd=%0d err=%0d",
                     bus.out_a, bus.out_b, bus.out_gcd, bus.out_err, e.a, e.b, e.g, e.e);
          end
        end
        tests++;
        if (bus.job_count !== exp_jobs) begin
          fails++;
          $display("FAIL sb_job_count: got %0d, required %0d", bus.job_count, exp_jobs);
        end
        exp_jobs++;
      end
    end
  end

  task automatic push_pair(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] g, input logic e, output bit ok);
    int unsigned n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge ap_clk); #1;
      n++;
    end
    ok = bus.in_ready;
    if (ok) begin
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      sb.push_back('{a, b, g, e});
      @(posedge ap_clk); #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(output bit ok);
    int unsigned n = 0;
    while ((sb.size() != 0 || bus.busy || bus.out_valid) && n < 1000) begin
      @(posedge ap_clk); #1;
      n++;
    end
    ok = (sb.size() == 0) && !bus.busy && !bus.out_valid;
  endtask

  task automatic wait_out_valid(output bit ok);
    int unsigned n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge ap_clk); #1;
      n++;
    end
    ok = bus.out_valid;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge ap_clk);
    #1;
    tests++;
    if ({bus.gcd_start, bus.out_valid, bus.out_err, bus.busy, bus.in_ready} !== 5'b00001) begin
      fails++;
      $display("FAIL reset_flags: got start,valid,err,busy,in_ready=%b, required 00001",
               {bus.gcd_start, bus.out_valid, bus.out_err, bus.busy, bus.in_ready});
    end
    tests++;
    if ({bus.gcd_a, bus.gcd_b, bus.out_a, bus.out_b, bus.out_gcd, bus.job_count} !== '0) begin
      fails++;
      $display("FAIL reset_data: got gcd_a=%0d gcd_b=%0d out_a=%0d out_b=%0d out_gcd=%0d jobs=%0d, required all 0",
               bus.gcd_a, bus.gcd_b, bus.out_a, bus.out_b, bus.out_gcd, bus.job_count);
    end
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;
  endtask

  task automatic test_basic;
    bit ok;
    lat = 5;
    start_seen = 1'b0;
    push_pair(32'd24, 32'd56, 32'd8, 1'b0, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL basic_push: got in_ready=0, required 1"); end
    wait_idle(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL basic_drain: got timeout, required idle"); end
    tests++;
    if (start_seen !== 1'b1) begin fails++; $display("FAIL basic_start: got %0b, required 1", start_seen); end
    tests++;
    if (bus.job_count !== 16'd1) begin fails++; $display("FAIL basic_jobs: got %0d, required 1", bus.job_count); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] tbl [5][3] = '{'{32'd12, 32'd18, 32'd6}, '{32'd7, 32'd13, 32'd1},
                                '{32'd100, 32'd75, 32'd25}, '{32'd81, 32'd27, 32'd27},
                                '{32'd64, 32'd48, 32'd16}};
    bit ok;
    lat = 10;
    for (int i = 0; i < 5; i++) begin
      push_pair(tbl[i][0], tbl[i][1], tbl[i][2], 1'b0, ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL b2b_push%0d: got in_ready=0, required 1", i); end
    end
    tests++;
    if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL b2b_full: got in_ready=%b, required 0", bus.in_ready); end
    tests++;
    if (bus.busy !== 1'b1) begin fails++; $display("FAIL b2b_busy: got %b, required 1", bus.busy); end
    wait_idle(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL b2b_drain: got timeout, required idle"); end
    tests++;
    if (bus.job_count !== 16'd6) begin fails++; $display("FAIL b2b_jobs: got %0d, required 6", bus.job_count); end
  endtask

  task automatic test_zero_ops;
    logic [31:0] za [2] = '{32'd0, 32'd0};
    logic [31:0] zb [2] = '{32'd15, 32'd0};
    bit ok;
    start_seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push_pair(za[i], zb[i], gcd_ref(za[i], zb[i]), 1'b0, ok);
      tests++;
      if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL zero_early%0d: got out_valid=%b, required 0", i, bus.out_valid); end
      @(posedge ap_clk); #1;
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_gcd !== gcd_ref(za[i], zb[i])) begin
        fails++;
        $display("FAIL zero_lat%0d: got out_valid=%b gcd=%0d, required 1 and %0d",
                 i, bus.out_valid, bus.out_gcd, gcd_ref(za[i], zb[i]));
      end
      @(posedge ap_clk); #1;
    end
    wait_idle(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL zero_drain: got timeout, required idle"); end
    tests++;
    if (start_seen !== 1'b0) begin fails++; $display("FAIL zero_start: got %0b, required 0", start_seen); end
  endtask

  task automatic test_stall;
    bit ok;
    lat = 5;
    bus.out_ready = 1'b0;
    push_pair(32'd21, 32'd14, 32'd7, 1'b0, ok);
    wait_out_valid(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL stall_valid: got out_valid=0, required 1"); end
    start_seen = 1'b0;
    push_pair(32'd30, 32'd12, 32'd6, 1'b0, ok);
    for (int i = 0; i < 10; i++) begin
      tests++;
      if ({bus.out_valid, bus.out_a, bus.out_b, bus.out_gcd, bus.out_err, bus.job_count, bus.gcd_start}
          !== {1'b1, 32'd21, 32'd14, 32'd7, 1'b0, 16'd8, 1'b0}) begin
        fails++;
        $display("FAIL stall_hold%0d: got valid=%b a=%0d b=%0d gcd=%0d err=%b jobs=%0d start=%b, required 1 21 14 7 0 8 0",
                 i, bus.out_valid, bus.out_a, bus.out_b, bus.out_gcd, bus.out_err, bus.job_count, bus.gcd_start);
      end
      @(posedge ap_clk); #1;
    end
    tests++;
    if (start_seen !== 1'b0) begin fails++; $display("FAIL stall_dispatch: got start_seen=%0b, required 0", start_seen); end
    bus.out_ready = 1'b1;
    wait_idle(ok);
    tests++;
    if (!ok || bus.job_count !== 16'd10) begin
      fails++;
      $display("FAIL stall_drain: got ok=%0b jobs=%0d, required 1 and 10", ok, bus.job_count);
    end
  endtask

  task automatic test_timeout;
    bit ok;
    lat = 5;
    hang = 1'b1;
    bus.out_ready = 1'b0;
    start_cycles = 0;
    push_pair(32'd9, 32'd6, 32'd0, 1'b1, ok);
    wait_out_valid(ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL tmo_valid: got out_valid=0, required 1"); end
    tests++;
    if (start_cycles != 16) begin fails++; $display("FAIL tmo_run_cycles: got %0d, required 16", start_cycles); end
    tests++;
    if ({bus.out_err, bus.out_gcd, bus.gcd_start} !== {1'b1, 32'd0, 1'b0}) begin
      fails++;
      $display("FAIL tmo_result: got err=%b gcd=%0d start=%b, required 1 0 0", bus.out_err, bus.out_gcd, bus.gcd_start);
    end
    hang = 1'b0;
    repeat (4) @(posedge ap_clk);
    #1;
    tests++;
    if ({bus.out_valid, bus.out_err, bus.out_gcd, bus.out_a} !== {1'b1, 1'b1, 32'd0, 32'd9}) begin
      fails++;
      $display("FAIL tmo_late_done: got valid=%b err=%b gcd=%0d a=%0d, required 1 1 0 9",
               bus.out_valid, bus.out_err, bus.out_gcd, bus.out_a);
    end
    bus.out_ready = 1'b1;
    push_pair(32'd24, 32'd56, 32'd8, 1'b0, ok);
    wait_idle(ok);
    tests++;
    if (!ok || bus.job_count !== 16'd12) begin
      fails++;
      $display("FAIL tmo_recover: got ok=%0b jobs=%0d, required 1 and 12", ok, bus.job_count);
    end
  endtask

  task automatic test_reset_in_run;
    bit ok;
    int unsigned n = 0;
    lat = 10;
    push_pair(32'd24, 32'd56, 32'd8, 1'b0, ok);
    push_pair(32'd30, 32'd12, 32'd6, 1'b0, ok);
    while (!bus.gcd_start && n < 50) begin
      @(posedge ap_clk); #1;
      n++;
    end
    tests++;
    if (bus.gcd_start !== 1'b1) begin fails++; $display("FAIL rst_run_start: got 0, required 1"); end
    @(posedge ap_clk); #3;
    ap_rst = 1'b1;
    #1;
    tests++;
    if ({bus.gcd_start, bus.out_valid, bus.busy, bus.in_ready, bus.job_count} !== {4'b0001, 16'd0}) begin
      fails++;
      $display("FAIL rst_run_state: got start=%b valid=%b busy=%b in_ready=%b jobs=%0d, required 0 0 0 1 0",
               bus.gcd_start, bus.out_valid, bus.busy, bus.in_ready, bus.job_count);
    end
    sb.delete();
    exp_jobs = 16'd0;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    lat = 5;
    push_pair(32'd24, 32'd56, 32'd8, 1'b0, ok);
    wait_idle(ok);
    tests++;
    if (!ok || bus.job_count !== 16'd1) begin
      fails++;
      $display("FAIL rst_run_fresh: got ok=%0b jobs=%0d, required 1 and 1", ok, bus.job_count);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero_ops();
    test_stall();
    test_timeout();
    test_reset_in_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
